// File: rtl/mem_rsp_pkg.sv
// Shared types and constants for the memory-side responder: read channel tags,
// read priority order and the supported RAM latency range.
package mem_rsp_pkg;

  typedef logic [1:0] ch_tag_t;

  localparam ch_tag_t CH_TRANS = 2'd0;
  localparam ch_tag_t CH_INST  = 2'd1;
  localparam ch_tag_t CH_DATA  = 2'd2;
  localparam ch_tag_t CH_NONE  = 2'd3;

  localparam int NUM_RD = 3;

  // Read channels from highest to lowest priority; the write slot outranks all of them.
  localparam ch_tag_t RD_PRIO [NUM_RD] = '{CH_TRANS, CH_DATA, CH_INST};

  localparam int RAM_LAT_MIN = 1;
  localparam int RAM_LAT_MAX = 4;

  typedef struct packed {
    logic        valid;
    ch_tag_t     tag;
    logic [31:0] addr;
  } rd_tag_t;

endpackage

// File: rtl/mem_rsp_rdpipe.sv
// Delay line carrying the channel tag and byte address of each issued read
// so they line up with the RAM read data.
module mem_rsp_rdpipe
  import mem_rsp_pkg::*;
#(
  parameter int DEPTH = 1
) (
  input  logic    clk_i,
  input  logic    rst_i,
  input  rd_tag_t in_i,
  output rd_tag_t out_o
);

  rd_tag_t stage_q [DEPTH];

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      for (int i = 0; i < DEPTH; i++) begin
        stage_q[i] <= '0;
      end
    end else begin
      stage_q[0] <= in_i;
      for (int i = 1; i < DEPTH; i++) begin
        stage_q[i] <= stage_q[i-1];
      end
    end
  end

  assign out_o = stage_q[DEPTH-1];

endmodule

// File: rtl/mem_responder.sv
// Memory-side responder: captures translation/instruction/data reads and data
// writes, issues them one per cycle to a single-port RAM and returns read data.
module mem_responder
  import mem_rsp_pkg::*;
#(
  parameter int ADDR_W      = 14,
  parameter int RAM_LATENCY = 1
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic              MEM_TRANS_RDEN,
  input  logic [31:0]       MEM_TRANS_RIADDR,
  output logic [31:0]       MEM_TRANS_ROADDR,
  output logic              MEM_TRANS_RVALID,
  output logic [31:0]       MEM_TRANS_RDATA,
  input  logic              MEM_INST_RDEN,
  input  logic [31:0]       MEM_INST_RIADDR,
  output logic [31:0]       MEM_INST_ROADDR,
  output logic              MEM_INST_RVALID,
  output logic [31:0]       MEM_INST_RDATA,
  input  logic              MEM_DATA_RDEN,
  input  logic [31:0]       MEM_DATA_RIADDR,
  output logic [31:0]       MEM_DATA_ROADDR,
  output logic              MEM_DATA_RVALID,
  output logic [31:0]       MEM_DATA_RDATA,
  input  logic              MEM_DATA_WREN,
  input  logic [3:0]        MEM_DATA_WSTRB,
  input  logic [31:0]       MEM_DATA_WADDR,
  input  logic [31:0]       MEM_DATA_WDATA,
  output logic              MEM_WAIT,
  output logic              RAM_EN,
  output logic [3:0]        RAM_WE,
  output logic [ADDR_W-1:0] RAM_ADDR,
  output logic [31:0]       RAM_WDATA,
  input  logic [31:0]       RAM_RDATA
);

  if (RAM_LATENCY < RAM_LAT_MIN || RAM_LATENCY > RAM_LAT_MAX) begin : g_lat_chk
    $error("mem_responder: RAM_LATENCY out of supported range");
  end

  logic              w_pend_q, w_pend_d;
  logic [31:0]       w_addr_q, w_addr_d;
  logic [3:0]        w_strb_q, w_strb_d;
  logic [31:0]       w_data_q, w_data_d;
  logic [NUM_RD-1:0] rd_pend_q, rd_pend_d;
  logic [31:0]       rd_addr_q [NUM_RD];
  logic [31:0]       rd_addr_d [NUM_RD];

  logic [NUM_RD-1:0] rd_req;
  logic [31:0]       rd_req_addr [NUM_RD];

  logic              wait_w;
  logic              iss_wr, iss_rd;
  ch_tag_t           iss_tag;
  logic [31:0]       iss_addr;
  rd_tag_t           pipe_in, pipe_out;

  logic [NUM_RD-1:0] rvalid_q;
  logic [31:0]       rdata_q  [NUM_RD];
  logic [31:0]       roaddr_q [NUM_RD];

  assign rd_req[CH_TRANS]      = MEM_TRANS_RDEN;
  assign rd_req[CH_INST]       = MEM_INST_RDEN;
  assign rd_req[CH_DATA]       = MEM_DATA_RDEN;
  assign rd_req_addr[CH_TRANS] = MEM_TRANS_RIADDR;
  assign rd_req_addr[CH_INST]  = MEM_INST_RIADDR;
  assign rd_req_addr[CH_DATA]  = MEM_DATA_RIADDR;

  // Captures are only blocked once a backlog exists; a single pending slot
  // drains at the same edge that new requests land.
  assign wait_w   = ($countones({w_pend_q, rd_pend_q}) >= 2);
  assign MEM_WAIT = wait_w;

  always_comb begin
    iss_wr   = 1'b0;
    iss_rd   = 1'b0;
    iss_tag  = CH_NONE;
    iss_addr = '0;
    if (w_pend_q) begin
      iss_wr   = 1'b1;
      iss_addr = w_addr_q;
    end else begin
      for (int p = 0; p < NUM_RD; p++) begin
        if (!iss_rd && rd_pend_q[RD_PRIO[p]]) begin
          iss_rd   = 1'b1;
          iss_tag  = RD_PRIO[p];
          iss_addr = rd_addr_q[RD_PRIO[p]];
        end
      end
    end
  end

  always_comb begin
    w_pend_d  = w_pend_q;
    w_addr_d  = w_addr_q;
    w_strb_d  = w_strb_q;
    w_data_d  = w_data_q;
    rd_pend_d = rd_pend_q;
    rd_addr_d = rd_addr_q;
    if (iss_wr) begin
      w_pend_d = 1'b0;
    end
    if (iss_rd) begin
      rd_pend_d[iss_tag] = 1'b0;
    end
    if (!wait_w) begin
      if (MEM_DATA_WREN && (MEM_DATA_WSTRB != 4'b0000)) begin
        w_pend_d = 1'b1;
        w_addr_d = MEM_DATA_WADDR;
        w_strb_d = MEM_DATA_WSTRB;
        w_data_d = MEM_DATA_WDATA;
      end
      for (int c = 0; c < NUM_RD; c++) begin
        if (rd_req[c]) begin
          rd_pend_d[c] = 1'b1;
          rd_addr_d[c] = rd_req_addr[c];
        end
      end
    end
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      w_pend_q  <= 1'b0;
      w_addr_q  <= '0;
      w_strb_q  <= '0;
      w_data_q  <= '0;
      rd_pend_q <= '0;
      for (int c = 0; c < NUM_RD; c++) begin
        rd_addr_q[c] <= '0;
      end
    end else begin
      w_pend_q  <= w_pend_d;
      w_addr_q  <= w_addr_d;
      w_strb_q  <= w_strb_d;
      w_data_q  <= w_data_d;
      rd_pend_q <= rd_pend_d;
      rd_addr_q <= rd_addr_d;
    end
  end

  assign RAM_EN    = iss_wr | iss_rd;
  assign RAM_WE    = iss_wr ? w_strb_q : 4'b0000;
  assign RAM_ADDR  = iss_addr[ADDR_W+1:2];
  assign RAM_WDATA = iss_wr ? w_data_q : 32'h0;

  logic unused_iss_addr_bits;
  assign unused_iss_addr_bits = ^{iss_addr[31:ADDR_W+2], iss_addr[1:0]};

  always_comb begin
    pipe_in       = '0;
    pipe_in.valid = iss_rd;
    pipe_in.tag   = iss_tag;
    pipe_in.addr  = iss_addr;
  end

  mem_rsp_rdpipe #(
    .DEPTH (RAM_LATENCY)
  ) u_rdpipe (
    .clk_i (CLK),
    .rst_i (RST),
    .in_i  (pipe_in),
    .out_o (pipe_out)
  );

  // Tag emerges together with RAM_RDATA; register both into the owning channel.
  always_ff @(posedge CLK) begin
    if (RST) begin
      rvalid_q <= '0;
      for (int c = 0; c < NUM_RD; c++) begin
        rdata_q[c]  <= '0;
        roaddr_q[c] <= '0;
      end
    end else begin
      rvalid_q <= '0;
      if (pipe_out.valid && (pipe_out.tag != CH_NONE)) begin
        rvalid_q[pipe_out.tag] <= 1'b1;
        rdata_q[pipe_out.tag]  <= RAM_RDATA;
        roaddr_q[pipe_out.tag] <= pipe_out.addr;
      end
    end
  end

  assign MEM_TRANS_RVALID = rvalid_q[CH_TRANS];
  assign MEM_TRANS_RDATA  = rdata_q[CH_TRANS];
  assign MEM_TRANS_ROADDR = roaddr_q[CH_TRANS];
  assign MEM_INST_RVALID  = rvalid_q[CH_INST];
  assign MEM_INST_RDATA   = rdata_q[CH_INST];
  assign MEM_INST_ROADDR  = roaddr_q[CH_INST];
  assign MEM_DATA_RVALID  = rvalid_q[CH_DATA];
  assign MEM_DATA_RDATA   = rdata_q[CH_DATA];
  assign MEM_DATA_ROADDR  = roaddr_q[CH_DATA];

endmodule

// File: doc/mem_responder.md
Name: mem_responder

Overview:
- Memory-side responder for the core's physical-address memory bus.
- Serves three read channels (translation table, instruction, data) and one data write channel.
- Arbitrates them onto a single single-port synchronous RAM, returns read data with the echoed address, and drives MEM_WAIT to stall the MMU and core when requests collide.
- Sits directly below the MMU.

Parameters:
- ADDR_W, 14, word-address width of backing RAM (2^ADDR_W 32-bit words).
- RAM_LATENCY, 1, RAM read latency in cycles (legal 1..4).

Ports:
- CLK  in  1  clock
- RST  in  1  synchronous active-high reset
- MEM_TRANS_RDEN  in  1  translation read request
- MEM_TRANS_RIADDR  in  32  translation read byte address
- MEM_TRANS_ROADDR  out  32  address of returned translation data
- MEM_TRANS_RVALID  out  1  translation data valid (1-cycle pulse)
- MEM_TRANS_RDATA  out  32  translation read data
- MEM_INST_RDEN / RIADDR / ROADDR / RVALID / RDATA  same as TRANS, instruction channel
- MEM_DATA_RDEN / RIADDR / ROADDR / RVALID / RDATA  same as TRANS, data channel
- MEM_DATA_WREN  in  1  write request
- MEM_DATA_WSTRB  in  4  byte enables
- MEM_DATA_WADDR  in  32  write byte address
- MEM_DATA_WDATA  in  32  write data
- MEM_WAIT  out  1  stall; requests are not sampled while high
- RAM_EN  out  1  RAM access enable
- RAM_WE  out  4  RAM byte write enables (0 = read)
- RAM_ADDR  out  ADDR_W  RAM word address
- RAM_WDATA  out  32  RAM write data
- RAM_RDATA  in  32  RAM read data, valid RAM_LATENCY cycles after the access

Behaviour:
- Clock/reset: one clock CLK; RST is synchronous, active-high.
- Capture: at each edge where MEM_WAIT=0, every asserted request (WREN with WSTRB!=0, TRANS/DATA/INST RDEN) is latched into a pending slot with its address, plus strobe/data for the write.
  - WREN with WSTRB=0 is ignored.
  - Inputs are don't-care while MEM_WAIT=1.
- Issue: each cycle, the highest-priority pending slot is driven to RAM and cleared at the next edge. Priority is fixed: WRITE > TRANS > DATA > INST.
  - RAM_EN=1 in an issue cycle, else 0.
  - RAM_ADDR = addr[ADDR_W+1:2]; upper bits and addr[1:0] are ignored, so out-of-range addresses wrap.
  - Write issue: RAM_WE=WSTRB, RAM_WDATA=WDATA.
  - Read issue: RAM_WE=0.
- MEM_WAIT: combinational; high iff 2 or more slots are pending.
  - With exactly one pending slot, it issues and new requests are captured at the same edge, so one request per cycle runs at full throughput with no stall.
- Ordering: a same-cycle write and read to one address return the new data (write issues first). Reads are returned in issue order.
- Read return: a channel tag and address enter a RAM_LATENCY-deep delay line at issue.
  - When the tag emerges, RAM_RDATA and the address are registered into that channel's RDATA/ROADDR, and its RVALID pulses for 1 cycle.
  - Single-request latency: RVALID is high RAM_LATENCY+1 cycles after the capture edge (2 cycles at default).
- RDATA/ROADDR hold their last value until that channel's next RVALID.
- Only one RVALID can be high per cycle.
- Reset values: all RVALID=0, RDATA=0, ROADDR=0, MEM_WAIT=0, RAM_EN=0, RAM_WE=0, RAM_ADDR=0, RAM_WDATA=0.
  - Pending slots and the delay line are cleared.
  - In-flight reads are dropped and no RVALID is produced for them after reset.
  - A write already issued to RAM is not undone.
- Worst case: all four requests captured at once. MEM_WAIT is high for 3 cycles, issue order is W, T, D, I, and all requests are completed by capture+4+RAM_LATENCY.

Decomposition:
- Package mem_rsp_pkg holds:
  - channel tag typedef (2 bits);
  - constants CH_TRANS=0, CH_INST=1, CH_DATA=2, CH_NONE=3;
  - the priority order;
  - the RAM_LATENCY legal range.
- One sub-module, mem_rsp_rdpipe: parameterised RAM_LATENCY-deep shift register of {valid, tag, 32-bit address}, synchronous clear on RST.

Test Plan:
- Single instruction read: RAM preloaded word 0x10 = 0xDEADBEEF; INST_RDEN, RIADDR=0x40 for 1 cycle -> INST_RVALID 2 cycles later with RDATA=0xDEADBEEF, ROADDR=0x40, MEM_WAIT stays 0.
- Back-to-back reads: INST_RDEN on 8 consecutive cycles, addresses 0x0..0x1C -> 8 consecutive RVALID pulses in address order, MEM_WAIT never high.
- Full collision: WREN (WADDR=0x80, WSTRB=0xF, WDATA=0x12345678), TRANS 0x100, DATA 0x80, INST 0x0 all in one cycle -> MEM_WAIT high 3 cycles, RAM issue order W, T, D, I, DATA_RDATA=0x12345678.
- Partial write: word at 0x20 = 0xAABBCCDD; write WSTRB=0x2, WDATA=0x00001100, then read 0x20 -> 0xAABB11DD. WREN with WSTRB=0 -> RAM_EN stays 0.
- Reset mid-flight: RAM_LATENCY=3, issue DATA read, assert RST one cycle later -> no DATA_RVALID ever; all outputs at reset values on the cycle after the RST edge.
- Address wrap: ADDR_W=14, read 0x00010040 -> RAM_ADDR=0x0010, ROADDR=0x00010040.
